// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, zero-skew registered sync/active, optional region flags.
// Define VGA_REGION_EN to build the NREG rectangle comparators behind region_hit.

`ifdef VGA_REGION_EN
module vga_region_cmp (
   input  logic [63:0] bounds,
   input  logic [15:0] col,
   input  logic [15:0] row,
   output logic        hit
);
   logic [15:0] x0, x1, y0, y1;

   // An inverted rectangle (x0>x1 or y0>y1) can never satisfy both inequalities.
   assign {x0, x1, y0, y1} = bounds;
   assign hit = (col >= x0) && (col <= x1) && (row >= y0) && (row <= y1);
endmodule
`endif

module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned NREG     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_en,
   input  logic [NREG*64-1:0]   reg_bounds,
   output logic [15:0]          column,
   output logic [15:0]          row,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 active,
   output logic                 line_start,
   output logic                 frame_start,
   output logic [NREG-1:0]      region_hit
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
   localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);

   logic [15:0] col_q, col_d, row_q, row_d;
   logic [15:0] col_nx, row_nx;
   logic        hsync_q, hsync_d, vsync_q, vsync_d;
   logic        active_q, active_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;

   always_comb begin
      col_nx = (col_q == H_LAST) ? 16'd0 : col_q + 16'd1;
      row_nx = row_q;
      if (col_q == H_LAST)
         row_nx = (row_q == V_LAST) ? 16'd0 : row_q + 16'd1;
   end

   // Sync/active decode from the next counts so they land in the same register as the counts.
   always_comb begin
      col_d         = col_q;
      row_d         = row_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_en) begin
         col_d         = col_nx;
         row_d         = row_nx;
         hsync_d       = (col_nx >= HS_FIRST && col_nx <= HS_LAST) ? HS_POL : ~HS_POL;
         vsync_d       = (row_nx >= VS_FIRST && row_nx <= VS_LAST) ? VS_POL : ~VS_POL;
         active_d      = (col_nx < H_VIS) && (row_nx < V_VIS);
         line_start_d  = (col_nx == 16'd0);
         frame_start_d = (col_nx == 16'd0) && (row_nx == 16'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q         <= '0;
         row_q         <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign column      = col_q;
   assign row         = row_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign active      = active_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_REGION_EN
   logic [NREG-1:0] cmp_hit;
   logic [NREG-1:0] region_hit_q, region_hit_d;

   for (genvar k = 0; k < NREG; k++) begin : g_reg
      vga_region_cmp u_cmp (
         .bounds (reg_bounds[64*k +: 64]),
         .col    (col_q),
         .row    (row_q),
         .hit    (cmp_hit[k])
      );
   end

   // Flags describe the position held before this tick, hence one tick behind column/row.
   always_comb begin
      region_hit_d = region_hit_q;
      if (pix_en)
         region_hit_d = cmp_hit & {NREG{active_q}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) region_hit_q <= '0;
      else        region_hit_q <= region_hit_d;
   end

   assign region_hit = region_hit_q;
`else
   logic unused_bounds;
   assign unused_bounds = ^reg_bounds;
   assign region_hit    = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-geometry and a default-geometry instance share stimulus; a model
// pushes the expected outputs per clock and a monitor pops and compares them.
module tb_vga_timing_gen;
   typedef struct {
      int ha, hf, hw, hb, va, vf, vw, vb;
      bit hp, vp;
   } geo_t;

   typedef struct {
      int col, row;
      bit hs, vs, act, ls, fs;
      bit [1:0] hit;
   } exp_t;

   typedef struct {
      exp_t s;
      exp_t d;
   } pair_t;

`ifdef VGA_REGION_EN
   localparam bit REG_EN = 1'b1;
`else
   localparam bit REG_EN = 1'b0;
`endif

   localparam geo_t GS = '{16, 2, 3, 3, 10, 2, 2, 3, 1'b1, 1'b0};
   localparam geo_t GD = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          pix_en = 1'b0;
   logic [127:0]  reg_bounds = '0;
   logic [127:0]  cur_b = '0;

   logic [15:0] s_col, s_row, d_col, d_row;
   logic        s_hs, s_vs, s_act, s_ls, s_fs, d_hs, d_vs, d_act, d_ls, d_fs;
   logic [1:0]  s_hit, d_hit;

   int total = 0;
   int bad = 0;
   pair_t q[$];
   exp_t ms, md;

   bit count_en = 1'b0;
   int cnt_hs_d = 0, cnt_ls_d = 0, cnt_hit0_d = 0, cnt_hit1_d = 0;
   int cnt_hs_s = 0, cnt_fs_s = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b1), .VS_POL(1'b0), .NREG(2)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .reg_bounds(reg_bounds),
      .column(s_col), .row(s_row), .hsync(s_hs), .vsync(s_vs), .active(s_act),
      .line_start(s_ls), .frame_start(s_fs), .region_hit(s_hit)
   );

   vga_timing_gen dut_d (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .reg_bounds(reg_bounds),
      .column(d_col), .row(d_row), .hsync(d_hs), .vsync(d_vs), .active(d_act),
      .line_start(d_ls), .frame_start(d_fs), .region_hit(d_hit)
   );

   function automatic exp_t rst_state(geo_t g);
      exp_t e;
      e.col = 0; e.row = 0; e.hs = !g.hp; e.vs = !g.vp;
      e.act = 0; e.ls = 0; e.fs = 0; e.hit = '0;
      return e;
   endfunction

   function automatic exp_t step(geo_t g, exp_t c, bit en, logic [127:0] b);
      exp_t n;
      int ht, vt;
      logic [15:0] x0, x1, y0, y1;
      n = c;
      n.ls = 0;
      n.fs = 0;
      if (!en) return n;
      ht = g.ha + g.hf + g.hw + g.hb;
      vt = g.va + g.vf + g.vw + g.vb;
      for (int k = 0; k < 2; k++) begin
         x0 = b[64*k+48 +: 16];
         x1 = b[64*k+32 +: 16];
         y0 = b[64*k+16 +: 16];
         y1 = b[64*k +: 16];
         n.hit[k] = REG_EN && c.act && c.col >= x0 && c.col <= x1 && c.row >= y0 && c.row <= y1;
      end
      n.col = (c.col == ht - 1) ? 0 : c.col + 1;
      n.row = c.row;
      if (n.col == 0) n.row = (c.row == vt - 1) ? 0 : c.row + 1;
      n.ls  = (n.col == 0);
      n.fs  = (n.col == 0) && (n.row == 0);
      n.act = (n.col < g.ha) && (n.row < g.va);
      n.hs  = (n.col >= g.ha + g.hf && n.col <= g.ha + g.hf + g.hw - 1) ? g.hp : !g.hp;
      n.vs  = (n.row >= g.va + g.vf && n.row <= g.va + g.vf + g.vw - 1) ? g.vp : !g.vp;
      return n;
   endfunction

   task automatic chk(string nm, int a, int e);
      total++;
      if (a != e) begin
         bad++;
         if (bad <= 30) $display("FAIL %s actual=%0d required=%0d at %0t", nm, a, e, $time);
      end
   endtask

   task automatic cmp_s(string tag, exp_t e);
      chk({tag, "_s_col"}, int'(s_col), e.col);
      chk({tag, "_s_row"}, int'(s_row), e.row);
      chk({tag, "_s_flags{hs,vs,act,ls,fs,hit}"}, int'({s_hs, s_vs, s_act, s_ls, s_fs, s_hit}),
          int'({e.hs, e.vs, e.act, e.ls, e.fs, e.hit}));
   endtask

   task automatic cmp_d(string tag, exp_t e);
      chk({tag, "_d_col"}, int'(d_col), e.col);
      chk({tag, "_d_row"}, int'(d_row), e.row);
      chk({tag, "_d_flags{hs,vs,act,ls,fs,hit}"}, int'({d_hs, d_vs, d_act, d_ls, d_fs, d_hit}),
          int'({e.hs, e.vs, e.act, e.ls, e.fs, e.hit}));
   endtask

   // Monitor: one expected entry per clock edge that the stimulus issued.
   always @(posedge clk) begin
      pair_t p;
      #1;
      if (q.size() > 0) begin
         p = q.pop_front();
         cmp_s("tick", p.s);
         cmp_d("tick", p.d);
         if (count_en) begin
            cnt_hs_d   += (d_hs == 1'b0) ? 1 : 0;
            cnt_ls_d   += d_ls ? 1 : 0;
            cnt_hit0_d += d_hit[0] ? 1 : 0;
            cnt_hit1_d += d_hit[1] ? 1 : 0;
            cnt_hs_s   += (s_hs == 1'b1) ? 1 : 0;
            cnt_fs_s   += s_fs ? 1 : 0;
         end
      end
   end

   task automatic tick(bit en);
      @(negedge clk);
      pix_en = en;
      reg_bounds = cur_b;
      ms = step(GS, ms, en, cur_b);
      md = step(GD, md, en, cur_b);
      q.push_back('{ms, md});
   endtask

   // Reset lands between clock edges; outputs are checked before any edge arrives.
   task automatic do_reset();
      @(negedge clk);
      pix_en = 1'b1;
      rst_n = 1'b0;
      #1;
      ms = rst_state(GS);
      md = rst_state(GD);
      cmp_s("async_rst", ms);
      cmp_d("async_rst", md);
      repeat (2) begin
         @(negedge clk);
         q.push_back('{ms, md});
      end
      @(negedge clk);
      rst_n = 1'b1;
      pix_en = 1'b0;
   endtask

   function automatic logic [63:0] rect(int x0, int x1, int y0, int y1);
      return {16'(x0), 16'(x1), 16'(y0), 16'(y1)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ms = rst_state(GS);
      md = rst_state(GD);
      cur_b = {rect(632, 8, 0, 479), rect(56, 582, 0, 1)};
      reg_bounds = cur_b;
      repeat (2) @(negedge clk);
      do_reset();

      // Free run for three default lines (about six small frames).
      count_en = 1'b1;
      for (int i = 0; i < 2400; i++) tick(1'b1);
      @(posedge clk);
      #2;
      count_en = 1'b0;
      chk("d_hsync_low_ticks", cnt_hs_d, 288);
      chk("d_line_starts", cnt_ls_d, 3);
      chk("d_region0_hits", cnt_hit0_d, REG_EN ? 1054 : 0);
      chk("d_region1_hits", cnt_hit1_d, 0);
      chk("s_hsync_high_ticks", cnt_hs_s, 300);
      chk("s_frame_starts", cnt_fs_s, 5);

      // Strobe 1-in-4 with a fresh reset and small-geometry rectangles.
      cur_b = {rect(9, 2, 0, 9), rect(3, 12, 2, 5)};
      do_reset();
      for (int i = 0; i < 600; i++) tick((i % 4) == 0);

      // Bounds change mid-frame takes effect on the following tick.
      for (int i = 0; i < 100; i++) tick(1'b1);
      cur_b = {rect(0, 15, 0, 9), rect(3, 12, 2, 5)};
      for (int i = 0; i < 816; i++) tick(1'b1);

      // Park mid-frame, then reset between edges.
      for (int i = 0; i < 400 && (ms.col == 0 || ms.row == 0); i++) tick(1'b1);
      do_reset();
      for (int i = 0; i < 30; i++) tick(1'b1);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640: visible columns.
REQ-002 SHALL provide parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths, in pixels.
REQ-003 SHALL provide parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical equivalents, in lines.
REQ-004 SHALL provide parameters HS_POL 0 and VS_POL 0: asserted sync level (0 = active-low).
REQ-005 SHALL provide parameter NREG, default 2: number of rectangular region comparators (range 1..8).
REQ-006 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-008 Port pix_en, input, 1: pixel-rate strobe; counters advance only when high.
REQ-009 Port reg_bounds, input, NREG*64: region k is bits [64k+63:64k] = {x0,x1,y0,y1}, 16 bits each, inclusive bounds.
REQ-010 Port column, output, 16: current horizontal count.
REQ-011 Port row, output, 16: current vertical count.
REQ-012 Ports hsync and vsync, outputs, 1 each: sync pulses at the levels set by HS_POL and VS_POL.
REQ-013 Port active, output, 1: high when column < H_ACTIVE and row < V_ACTIVE.
REQ-014 Ports line_start and frame_start, outputs, 1 each: single-clk pulses.
REQ-015 Port region_hit, output, NREG: per-region inside flags.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be used (defaults: 800 and 525).
REQ-017 On each clk with pix_en=1, column SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and row SHALL increment; row SHALL wrap from V_TOTAL-1 to 0 on the same tick as column wraps.
REQ-018 With pix_en=0, every counter and registered output SHALL hold, and line_start and frame_start SHALL be 0.
REQ-019 hsync SHALL be asserted iff column is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (defaults: 656..751).
REQ-020 vsync SHALL be asserted iff row is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (defaults: 490..491).
REQ-021 hsync, vsync and active SHALL be registered, decoded from next-state counts, and aligned with the row/column values they describe (zero skew).
REQ-022 line_start SHALL pulse for one clk when column becomes 0; frame_start SHALL pulse for one clk when row and column both become 0.
REQ-023 region_hit[k] SHALL be registered with one pix_en tick of latency: high iff x0<=column<=x1, y0<=row<=y1 and active were all true at the previous tick.
REQ-024 If x0>x1 or y0>y1, region_hit[k] SHALL stay 0.
REQ-025 reg_bounds SHALL be sampled every tick; a change SHALL take effect on the next tick, with no frame-boundary shadowing.
REQ-026 All comparisons SHALL be unsigned, 16-bit.

Reset
REQ-027 While rst_n=0: column=0, row=0, active=0, line_start=0, frame_start=0, region_hit=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-028 After rst_n deasserts, the first pix_en tick SHALL move column to 1; line_start and frame_start SHALL NOT pulse for the reset state.
REQ-029 Reset asserted mid-frame SHALL force the REQ-027 values immediately, without waiting for clk.

Configuration
REQ-030 Macro VGA_REGION_EN: when defined, the NREG comparators and region_hit pipeline SHALL be built as in REQ-023..025; when undefined, region_hit SHALL be tied to 0, reg_bounds SHALL be ignored, and no comparator logic SHALL be synthesised.

Verification
REQ-031 Reset, then pix_en held high -> column runs 0..799, row increments at the wrap, and line_start pulses every 800 ticks.
REQ-032 Default parameters -> hsync low exactly for columns 656..751 (96 ticks); vsync low exactly for rows 490..491 (1600 ticks); active high for 640x480 pixels per frame.
REQ-033 Free-running -> frame_start pulses once every 420000 pix_en ticks, coincident with row=0 and column=0.
REQ-034 Region 0 bounds {56,582,400,415} -> region_hit[0] high for 527 ticks per line on rows 400..415, one tick after the matching column; region 1 bounds {632,8,0,479} -> never hit.
REQ-035 pix_en toggled 1-in-4 -> outputs update only on strobe cycles and hold otherwise; rst_n pulsed low at row 300, column 400 -> outputs immediately take the REQ-027 values.
REQ-036 Built without VGA_REGION_EN -> region_hit = 0 for any reg_bounds, and all other checks still pass.
